pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning max consecutive MEM-wait cycles before the controller halts (range 1..255).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports ID_rs, ID_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports ID_UsesRs, ID_UsesRt  in  1 each  the ID instruction actually reads rs/rt.
REQ-006 SHALL have port ID_Jump  in  1  an unconditional jump is decoded in ID.
REQ-007 SHALL have ports EX_MemRead  in  1 and EX_rt  in  5  load in EX and its destination register.
REQ-008 SHALL have port EX_BranchTaken  in  1  the branch in EX resolved as taken.
REQ-009 SHALL have ports MEM_Req, MEM_Ready  in  1 each  MEM-stage access pending / data memory completes this cycle.
REQ-010 SHALL have outputs PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  1 each  stage-register update enables.
REQ-011 SHALL have outputs IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  1 each  insert bubble into that stage register.
REQ-012 SHALL have outputs Halted  1  controller is in HALT, and Stall_Cycles  16  saturating count of cycles with PC_Write=0.

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT, HALT; outputs are Mealy, decoded from state plus current inputs.
REQ-014 SHALL in RUN with MEM_Req=1 and MEM_Ready=0 drive all four *_Write=0 and MEM_WB_Flush=1 in the same cycle, and enter MEM_WAIT next cycle.
REQ-015 SHALL in MEM_WAIT hold the same freeze outputs while MEM_Ready=0; on MEM_Ready=1 release the freeze in that cycle (all *_Write=1) and return to RUN next cycle.
REQ-016 SHALL keep an 8-bit wait counter, cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle with MEM_Ready=0; the counter reaching MEM_TIMEOUT SHALL cause entry to HALT.
REQ-017 SHALL in HALT hold all *_Write=0, MEM_WB_Flush=1, Halted=1, ignoring all inputs until reset.
REQ-018 SHALL, when not frozen, treat load-use as EX_MemRead=1, EX_rt!=0, and ((ID_UsesRs and ID_rs==EX_rt) or (ID_UsesRt and ID_rt==EX_rt)).
REQ-019 SHALL on load-use drive PC_Write=0, IF_ID_Write=0 and ID_EX_Flush=1 for exactly that cycle.
REQ-020 SHALL on EX_BranchTaken=1 drive IF_ID_Flush=1 and ID_EX_Flush=1 with PC_Write=1, overriding load-use and ID_Jump.
REQ-021 SHALL on ID_Jump=1 without branch or load-use drive IF_ID_Flush=1 with PC_Write=1.
REQ-022 SHALL apply priority MEM freeze/HALT > EX_BranchTaken > load-use > ID_Jump.
REQ-023 SHALL during a freeze assert no IF_ID_Flush or ID_EX_Flush; a pending branch, hazard or jump SHALL be acted on in the first unfrozen cycle.
REQ-024 SHALL default to all *_Write=1 and all flushes 0 in RUN with no hazard.
REQ-025 SHALL increment Stall_Cycles on every cycle with PC_Write=0, saturating at 16'hFFFF.

Reset
REQ-026 SHALL on reset enter RUN and clear the wait counter, Stall_Cycles and Halted; reset SHALL override every state, including HALT and mid-MEM_WAIT.
REQ-027 SHALL while reset is high drive all *_Write=1 and all flushes 0.

Structure
REQ-028 SHALL place the FSM state encoding (2-bit: RUN=0, MEM_WAIT=1, HALT=2) and the MEM_TIMEOUT default in the shared CPU constants package.
REQ-029 SHALL isolate load-use comparison in sub-module load_use_detect (combinational); the FSM and counters stay in the top module.

Verification
REQ-030 Load-use: EX_MemRead=1, EX_rt=8, ID_rs=8, ID_UsesRs=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; Stall_Cycles +1.
REQ-031 Zero register: same as REQ-030 with EX_rt=0 -> no stall, all *_Write=1.
REQ-032 Branch beats load-use: load-use condition plus EX_BranchTaken=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
REQ-033 MEM wait: MEM_Req=1, MEM_Ready=0 for 3 cycles, then 1 -> 3 frozen cycles with MEM_WB_Flush=1, release on the 4th; Stall_Cycles=3.
REQ-034 Timeout: MEM_TIMEOUT=4, MEM_Ready held 0 -> Halted=1 after 4 wait cycles; stays halted; reset -> RUN, Stall_Cycles=0.
REQ-035 Saturation: force 70000 stall cycles -> Stall_Cycles=16'hFFFF, no wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU constants for the pipeline hazard controller: FSM encoding and
// the default MEM-wait timeout.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StHalt    = 2'd2
   } hazard_state_e;

   localparam int unsigned MemTimeoutDefault = 255;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the ID instruction reads the register a
// load in EX is about to write.
module load_use_detect (
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rt_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_uses_rs_i,
   input  logic       id_uses_rt_i,
   output logic       load_use_o
);

   logic rs_hit;
   logic rt_hit;

   always_comb begin
      rs_hit     = id_uses_rs_i && (id_rs_i == ex_rt_i);
      rt_hit     = id_uses_rt_i && (id_rt_i == ex_rt_i);
      // r0 is hardwired to zero, so a load into it never creates a dependency
      load_use_o = ex_mem_read_i && (ex_rt_i != 5'd0) && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: MEM-wait freeze with timeout halt, branch/jump
// flushes and load-use stalls, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_UsesRs,
   input  logic        ID_UsesRt,
   input  logic        ID_Jump,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic        EX_BranchTaken,
   input  logic        MEM_Req,
   input  logic        MEM_Ready,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        ID_EX_Write,
   output logic        EX_MEM_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Flush,
   output logic        MEM_WB_Flush,
   output logic        Halted,
   output logic [15:0] Stall_Cycles
);

   localparam logic [8:0] TimeoutLimit = 9'(MEM_TIMEOUT);

   hazard_state_e state_q;
   logic [7:0]    wait_cnt_q;
   logic [15:0]   stall_q;
   logic          load_use;
   logic          frozen;

   load_use_detect u_load_use_detect (
      .ex_mem_read_i (EX_MemRead),
      .ex_rt_i       (EX_rt),
      .id_rs_i       (ID_rs),
      .id_rt_i       (ID_rt),
      .id_uses_rs_i  (ID_UsesRs),
      .id_uses_rt_i  (ID_UsesRt),
      .load_use_o    (load_use)
   );

   always_comb begin
      frozen = (state_q == StHalt)
            || (state_q == StMemWait && !MEM_Ready)
            || (state_q == StRun && MEM_Req && !MEM_Ready);

      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;
      MEM_WB_Flush = 1'b0;

      if (!reset) begin
         // Freeze suppresses front-end flushes; pending hazards are re-seen once released
         if (frozen) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
         end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
         end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
         end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StRun;
         wait_cnt_q <= 8'd0;
         stall_q    <= 16'd0;
      end else begin
         if (!PC_Write && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
         end
         unique case (state_q)
            StRun: begin
               if (MEM_Req && !MEM_Ready) begin
                  state_q    <= StMemWait;
                  wait_cnt_q <= 8'd0;
               end
            end
            StMemWait: begin
               if (MEM_Ready) begin
                  state_q <= StRun;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
                  if ({1'b0, wait_cnt_q} + 9'd1 >= TimeoutLimit) begin
                     state_q <= StHalt;
                  end
               end
            end
            StHalt: begin
               state_q <= StHalt;
            end
            default: begin
               state_q <= StRun;
            end
         endcase
      end
   end

   assign Halted       = (state_q == StHalt);
   assign Stall_Cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table of single-cycle hazard
// vectors plus hand-written MEM-wait, timeout/halt and saturation sequences.
module tb_pipeline_hazard_ctrl;

   // {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}
   localparam logic [6:0] OutIdle = 7'b1111_000;
   localparam logic [6:0] OutLu   = 7'b0011_010;
   localparam logic [6:0] OutBr   = 7'b1111_110;
   localparam logic [6:0] OutJmp  = 7'b1111_100;
   localparam logic [6:0] OutFrz  = 7'b0000_001;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rs;
      logic       uses_rt;
      logic       jump;
      logic       mem_read;
      logic [4:0] ex_rt;
      logic       br;
      logic [6:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ID_rs, ID_rt, EX_rt;
   logic        ID_UsesRs, ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken;
   logic        MEM_Req, MEM_Ready;
   logic        PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
   logic        IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, Halted;
   logic [15:0] Stall_Cycles;
   logic [6:0]  outs;

   int errors = 0;
   int checks = 0;
   vec_t vecs[10];

   always #5 clk = ~clk;

   assign outs = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                  IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush};

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .ID_rs          (ID_rs),
      .ID_rt          (ID_rt),
      .ID_UsesRs      (ID_UsesRs),
      .ID_UsesRt      (ID_UsesRt),
      .ID_Jump        (ID_Jump),
      .EX_MemRead     (EX_MemRead),
      .EX_rt          (EX_rt),
      .EX_BranchTaken (EX_BranchTaken),
      .MEM_Req        (MEM_Req),
      .MEM_Ready      (MEM_Ready),
      .PC_Write       (PC_Write),
      .IF_ID_Write    (IF_ID_Write),
      .ID_EX_Write    (ID_EX_Write),
      .EX_MEM_Write   (EX_MEM_Write),
      .IF_ID_Flush    (IF_ID_Flush),
      .ID_EX_Flush    (ID_EX_Flush),
      .MEM_WB_Flush   (MEM_WB_Flush),
      .Halted         (Halted),
      .Stall_Cycles   (Stall_Cycles)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
      EX_MemRead = 1'b0; EX_rt = 5'd0; EX_BranchTaken = 1'b0;
      MEM_Req = 1'b0; MEM_Ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      //          rs     rt     urs   urt   jmp   mrd   ex_rt  br    exp
      vecs[0] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, OutIdle};
      vecs[1] = '{5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, OutLu};
      vecs[2] = '{5'd3,  5'd8,  1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b0, OutLu};
      vecs[3] = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, OutIdle};
      vecs[4] = '{5'd8,  5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, OutIdle};
      vecs[5] = '{5'd8,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 5'd8,  1'b0, OutIdle};
      vecs[6] = '{5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, OutBr};
      vecs[7] = '{5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0, OutJmp};
      vecs[8] = '{5'd9,  5'd2,  1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0, OutLu};
      vecs[9] = '{5'd1,  5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, OutBr};

      // Outputs forced to defaults while reset is high, even with a MEM miss present
      reset = 1'b1;
      idle_inputs();
      MEM_Req = 1'b1;
      #1;
      check("reset_outputs", 16'(outs), 16'(OutIdle));
      @(negedge clk);
      check("reset_halted", 16'(Halted), 16'd0);
      check("reset_stall", Stall_Cycles, 16'd0);
      reset = 1'b0;
      idle_inputs();

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         ID_rs = vecs[i].rs; ID_rt = vecs[i].rt;
         ID_UsesRs = vecs[i].uses_rs; ID_UsesRt = vecs[i].uses_rt;
         ID_Jump = vecs[i].jump; EX_MemRead = vecs[i].mem_read;
         EX_rt = vecs[i].ex_rt; EX_BranchTaken = vecs[i].br;
         #1;
         check($sformatf("vec%0d_outputs", i), 16'(outs), 16'(vecs[i].exp));
      end
      @(negedge clk);
      idle_inputs();
      #1;
      check("vec_stall_count", Stall_Cycles, 16'd3);
      check("vec_halted", 16'(Halted), 16'd0);

      // MEM wait: 3 frozen cycles with a branch pending, released on the 4th
      do_reset();
      MEM_Req = 1'b1; MEM_Ready = 1'b0; EX_BranchTaken = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("memwait_frozen%0d", c), 16'(outs), 16'(OutFrz));
         @(negedge clk);
      end
      MEM_Ready = 1'b1;
      #1;
      check("memwait_release", 16'(outs), 16'(OutBr));
      @(negedge clk);
      idle_inputs();
      #1;
      check("memwait_back_run", 16'(outs), 16'(OutIdle));
      check("memwait_stall", Stall_Cycles, 16'd3);
      check("memwait_halted", 16'(Halted), 16'd0);

      // Timeout: 1 RUN freeze cycle + 4 MEM_WAIT cycles, then HALT
      do_reset();
      MEM_Req = 1'b1; MEM_Ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("timeout_not_halted%0d", c), 16'(Halted), 16'd0);
         @(negedge clk);
      end
      #1;
      check("timeout_halted", 16'(Halted), 16'd1);
      check("timeout_stall", Stall_Cycles, 16'd5);
      @(negedge clk);
      MEM_Req = 1'b0; MEM_Ready = 1'b1; EX_BranchTaken = 1'b1; ID_Jump = 1'b1;
      #1;
      check("halt_ignores_inputs", 16'(outs), 16'(OutFrz));
      check("halt_sticky", 16'(Halted), 16'd1);

      // Halt stalls every cycle, so the counter must saturate
      repeat (70000) @(negedge clk);
      #1;
      check("stall_saturated", Stall_Cycles, 16'hFFFF);
      @(negedge clk);
      #1;
      check("stall_no_wrap", Stall_Cycles, 16'hFFFF);

      do_reset();
      #1;
      check("post_reset_halted", 16'(Halted), 16'd0);
      check("post_reset_stall", Stall_Cycles, 16'd0);
      check("post_reset_outputs", 16'(outs), 16'(OutIdle));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
